spi_master_shifter: RTL and testbench
=====================================

Name: spi_master_shifter

Overview:
- SPI mode 0 (CPOL=0, CPHA=0) master shift engine for the SPI interface path.
- Sits directly upstream of the SCLK clock divider:
  - drives that divider's SCLK enable;
  - consumes its one-cycle pos_edge/neg_edge strobes to time MOSI shifting and MISO sampling.
- Accepts a parallel word via start/busy handshake, frames it with CS, returns the received word with a done pulse.

Parameters:
- DATA_W, 8, bits per transfer (MSB first); legal 2..32.
- CS_SETUP, 4, clk_10MHz cycles between CS assertion and SCLK enable; legal >=1.
- CS_HOLD, 4, clk_10MHz cycles between SCLK disable and CS deassertion; legal >=1.

Ports:
- clk_10MHz  in  1  system clock (10 MHz).
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  transfer request; sampled only in IDLE.
- tx_data_i  in  DATA_W  word to transmit; captured on accepted start.
- pos_edge_i  in  1  divider strobe: SCLK rising edge occurred (1 cycle wide).
- neg_edge_i  in  1  divider strobe: SCLK falling edge occurred (1 cycle wide).
- miso_i  in  1  serial data from slave (pre-synchronised externally).
- en_sclk_o  out  1  enable to divider; low holds divider counter and SCLK at 0.
- cs_n_o  out  1  slave chip select, active-low.
- mosi_o  out  1  serial data to slave.
- rx_data_o  out  DATA_W  last received word; holds until next done.
- busy_o  out  1  high from start acceptance until done.
- done_o  out  1  one-cycle pulse: transfer complete, rx_data_o valid.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, cs_n_o=1, en_sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_o=0, shift regs and counters=0.
- Reset mid-transfer aborts the transfer with no done. Because en_sclk_o drops, the divider returns SCLK to 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - start_i=1 at a clock edge: tx_shift<=tx_data_i; mosi_o<=tx_data_i[DATA_W-1]; cs_n_o<=0; busy_o<=1; bit_cnt<=0; timer<=0; ->SETUP.
  - start_i=0: remain in IDLE, outputs unchanged.
- SETUP:
  - timer increments each cycle.
  - When timer==CS_SETUP-1: en_sclk_o<=1; ->SHIFT.
  - So SCLK is enabled exactly CS_SETUP cycles after cs_n_o falls.
- SHIFT:
  - On pos_edge_i: rx_shift<={rx_shift[DATA_W-2:0], miso_i}; bit_cnt<=bit_cnt+1.
  - On neg_edge_i with bit_cnt<DATA_W: tx_shift<=tx_shift<<1; mosi_o<=tx_shift[DATA_W-2] (next bit).
  - On neg_edge_i with bit_cnt==DATA_W: en_sclk_o<=0; mosi_o<=0; timer<=0; ->HOLD.
  - SCLK therefore idles low after exactly DATA_W full periods.
  - Both strobes high in the same cycle (divider misuse): pos_edge_i is processed, neg_edge_i is ignored.
  - Strobes outside SHIFT are ignored.
- HOLD:
  - timer increments.
  - When timer==CS_HOLD-1: cs_n_o<=1; rx_data_o<=rx_shift; done_o<=1; busy_o<=0; ->IDLE.
- done_o is deasserted the following cycle.
- start_i in the cycle where done_o=1 is accepted (state already IDLE, busy_o=0). This gives back-to-back transfers with cs_n_o high for exactly 1 cycle.
- start_i while busy_o=1 is ignored; tx_data_i changes during a transfer have no effect.
- bit_cnt width is $clog2(DATA_W+1); timer width covers max(CS_SETUP, CS_HOLD).

Test Plan:
- Reset during IDLE, then release -> cs_n_o=1, en_sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_o=0.
- DATA_W=8, tx_data_i=0xA5, slave model returns 0x3C on MISO (changing on SCLK fall), divider attached -> MOSI at each SCLK rise reads 1,0,1,0,0,1,0,1.
  - Exactly 8 SCLK rises.
  - cs_n_o low 4 cycles before the first en_sclk_o and 4 cycles after it drops.
  - done_o pulses once; rx_data_o=0x3C; busy_o falls with done_o.
- Back-to-back: start_i held high, words 0xFF then 0x00 -> second transfer starts the cycle after done_o; cs_n_o high exactly 1 cycle between transfers; rx words match slave pattern.
- start_i pulsed and tx_data_i changed to 0x11 mid-transfer of 0xC3 -> ignored; MOSI still serialises 0xC3; only one done_o.
- Assert rst_i asynchronously after the 3rd pos_edge_i -> outputs return to reset values without a clock edge; no done_o; rx_data_o stays 0; the next start completes normally.
- Force pos_edge_i and neg_edge_i high together in SHIFT -> bit_cnt increments once and mosi_o is unchanged that cycle.

Source files
------------

// File: rtl/spi_master_shifter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_master_shifter
//
// SPI mode 0 (CPOL=0, CPHA=0) master shift engine. It sits in front of an
// external SCLK divider. It enables that divider while a word is being moved
// and uses the divider's one-cycle edge strobes to decide when to act:
//   - rising SCLK edge  : sample MISO into the receive shifter
//   - falling SCLK edge : present the next MOSI bit, or end the frame after
//                         the last bit
// A transfer is framed by chip select. CS_SETUP cycles separate CS falling
// from SCLK enable, and CS_HOLD cycles separate SCLK disable from CS rising.
//
// Parameters
//   DATA_W    bits per transfer, MSB first (2..32)
//   CS_SETUP  cycles from cs_n_o low to en_sclk_o high (>=1)
//   CS_HOLD   cycles from en_sclk_o low to cs_n_o high (>=1)
//
// Ports
//   clk_10MHz   in   system clock
//   rst_i       in   asynchronous active-high reset
//   start_i     in   transfer request, only looked at while idle
//   tx_data_i   in   word to send, captured when start is accepted
//   pos_edge_i  in   divider strobe, SCLK has just risen
//   neg_edge_i  in   divider strobe, SCLK has just fallen
//   miso_i      in   serial data from the slave (already synchronised)
//   en_sclk_o   out  divider enable, low parks SCLK at 0
//   cs_n_o      out  active-low slave select
//   mosi_o      out  serial data to the slave
//   rx_data_o   out  last received word, held until the next done
//   busy_o      out  high from start acceptance until done
//   done_o      out  one-cycle pulse, rx_data_o is valid
// ---------------------------------------------------------------------------
module spi_master_shifter #(
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic              clk_10MHz,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              pos_edge_i,
  input  logic              neg_edge_i,
  input  logic              miso_i,
  output logic              en_sclk_o,
  output logic              cs_n_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o
);

  // The timer only ever needs to reach max(CS_SETUP, CS_HOLD) - 1.
  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int CNT_W   = $clog2(DATA_W + 1);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] BITS_ALL   = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [TMR_W-1:0]  timer_q;

  logic [DATA_W-1:0] tx_shift_d;
  logic [DATA_W-1:0] rx_shift_d;
  logic [CNT_W-1:0]  bit_cnt_d;
  logic [TMR_W-1:0]  timer_d;
  logic              fall_only;
  logic              all_bits_in;

  // Next values for the datapath registers. A falling strobe only counts
  // when the rising strobe is absent: if a misbehaving divider raises both
  // at once, the sample wins and the MOSI update is dropped for that cycle.
  always_comb begin
    tx_shift_d  = tx_shift_q << 1;
    rx_shift_d  = {rx_shift_q[DATA_W-2:0], miso_i};
    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
    timer_d     = timer_q + TMR_W'(1);
    fall_only   = neg_edge_i & ~pos_edge_i;
    all_bits_in = (bit_cnt_q == BITS_ALL);
  end

  // Single FSM with every output registered. mosi_o is loaded with the MSB
  // at acceptance so it is already stable before the first rising edge;
  // afterwards it only changes on falling edges, which is what mode 0 needs.
  always_ff @(posedge clk_10MHz or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      en_sclk_o  <= 1'b0;
      cs_n_o     <= 1'b1;
      mosi_o     <= 1'b0;
      rx_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            tx_shift_q <= tx_data_i;
            mosi_o     <= tx_data_i[DATA_W-1];
            cs_n_o     <= 1'b0;
            busy_o     <= 1'b1;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          timer_q <= timer_d;
          if (timer_q == SETUP_LAST) begin
            en_sclk_o <= 1'b1;
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (pos_edge_i) begin
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
          end else if (fall_only) begin
            // The falling edge after the last sample closes the frame, so
            // SCLK is left low after exactly DATA_W periods.
            if (all_bits_in) begin
              en_sclk_o <= 1'b0;
              mosi_o    <= 1'b0;
              timer_q   <= '0;
              state_q   <= HOLD;
            end else begin
              tx_shift_q <= tx_shift_d;
              mosi_o     <= tx_shift_q[DATA_W-2];
            end
          end
        end

        HOLD: begin
          timer_q <= timer_d;
          if (timer_q == HOLD_LAST) begin
            cs_n_o    <= 1'b1;
            rx_data_o <= rx_shift_q;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_spi_master_shifter
//
// Bench for the SPI mode 0 shift engine. A small SCLK divider model and a
// mode 0 slave model surround the DUT. Each started transfer pushes its
// expected received word and MOSI word to a queue; a monitor pops the entry
// when done_o pulses and compares. CS framing timing is checked for every
// transfer by the same monitor.
// ---------------------------------------------------------------------------
module tb_spi_master_shifter;

  localparam int DATA_W   = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int HALF     = 3;

  logic              clk_10MHz = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              pos_edge_i;
  logic              neg_edge_i;
  logic              miso_i;
  logic              en_sclk_o;
  logic              cs_n_o;
  logic              mosi_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              busy_o;
  logic              done_o;

  // Manual strobe override used for the simultaneous-strobe case.
  logic              forceMode;
  logic              fPos;
  logic              fNeg;
  logic              fMiso;

  logic              sclk    = 1'b0;
  logic              divPos  = 1'b0;
  logic              divNeg  = 1'b0;
  int                divCnt  = 0;
  logic              sclkPrevS = 1'b0;
  int                sbit    = DATA_W - 1;
  logic [DATA_W-1:0] slavePattern;

  typedef struct {
    logic [DATA_W-1:0] rx;
    logic [DATA_W-1:0] tx;
    bit                chkTx;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] expRx;
    logic [DATA_W-1:0] expMosi;
  } vec_t;
  vec_t vecs[5];

  int total     = 0;
  int bad       = 0;
  int doneCount = 0;

  spi_master_shifter #(
    .DATA_W  (DATA_W),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk_10MHz (clk_10MHz),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .tx_data_i (tx_data_i),
    .pos_edge_i(pos_edge_i),
    .neg_edge_i(neg_edge_i),
    .miso_i    (miso_i),
    .en_sclk_o (en_sclk_o),
    .cs_n_o    (cs_n_o),
    .mosi_o    (mosi_o),
    .rx_data_o (rx_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  assign pos_edge_i = forceMode ? fPos  : divPos;
  assign neg_edge_i = forceMode ? fNeg  : divNeg;
  assign miso_i     = forceMode ? fMiso : slavePattern[sbit];

  // Divider model: SCLK toggles every HALF clocks while enabled, with a
  // registered strobe marking each edge; disabled means counter and SCLK 0.
  always @(posedge clk_10MHz) begin
    if (!en_sclk_o) begin
      divCnt <= 0;
      sclk   <= 1'b0;
      divPos <= 1'b0;
      divNeg <= 1'b0;
    end else begin
      divPos <= 1'b0;
      divNeg <= 1'b0;
      if (divCnt == HALF - 1) begin
        divCnt <= 0;
        sclk   <= ~sclk;
        if (!sclk) divPos <= 1'b1;
        else       divNeg <= 1'b1;
      end else begin
        divCnt <= divCnt + 1;
      end
    end
  end

  // Mode 0 slave: MSB ready while selected, next bit after each SCLK fall.
  always @(posedge clk_10MHz) begin
    sclkPrevS <= sclk;
    if (cs_n_o)                              sbit <= DATA_W - 1;
    else if (sclkPrevS && !sclk && sbit > 0) sbit <= sbit - 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got timeout, want event", name);
  endtask

  // Drive one start pulse and record what the transfer must produce.
  task automatic applyStimulus(input logic [DATA_W-1:0] tx,
                               input logic [DATA_W-1:0] pat,
                               input logic [DATA_W-1:0] expRx,
                               input logic [DATA_W-1:0] expMosi,
                               input bit chk);
    exp_t e;
    e.rx = expRx;
    e.tx = expMosi;
    e.chkTx = chk;
    sbq.push_back(e);
    slavePattern = pat;
    tx_data_i = tx;
    start_i = 1'b1;
    @(negedge clk_10MHz);
    start_i = 1'b0;
  endtask

  // Returns at the falling edge where done_o is seen high.
  task automatic waitDone(input int limit, input string name);
    int n = 0;
    while (!done_o && n < limit) begin
      @(negedge clk_10MHz);
      n++;
    end
    if (!done_o) timeoutFail(name);
  endtask

  task automatic waitEn(input int limit, input string name);
    int n = 0;
    while (!en_sclk_o && n < limit) begin
      @(negedge clk_10MHz);
      n++;
    end
    if (!en_sclk_o) timeoutFail(name);
  endtask

  // Monitor: MOSI capture at SCLK rise, CS framing timing, done scoreboard.
  initial begin
    int                phase = 0;
    int                cnt = 0;
    int                riseCnt = 0;
    logic [DATA_W-1:0] txCap = '0;
    logic              sclkPrevM = 1'b0;
    logic              lastDone = 1'b0;
    exp_t              e;
    forever begin
      @(negedge clk_10MHz);
      if (rst_i) begin
        phase = 0;
        sclkPrevM = 1'b0;
        lastDone = 1'b0;
      end else begin
        if (sclk && !sclkPrevM) begin
          txCap = {txCap[DATA_W-2:0], mosi_o};
          riseCnt++;
        end
        sclkPrevM = sclk;
        case (phase)
          0: if (!cs_n_o) begin phase = 1; cnt = 1; riseCnt = 0; txCap = '0; end
          1: if (en_sclk_o) begin checkOutput("cs_setup_cycles", cnt, CS_SETUP); phase = 2; end
             else cnt++;
          2: if (!en_sclk_o) begin phase = 3; cnt = 1; end
          default: if (cs_n_o) begin checkOutput("cs_hold_cycles", cnt, CS_HOLD); phase = 0; end
             else cnt++;
        endcase
        if (done_o) begin
          doneCount++;
          checkOutput("done_width", lastDone, 0);
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got done pulse, want none");
          end else begin
            e = sbq.pop_front();
            checkOutput("rx_data", rx_data_o, e.rx);
            checkOutput("busy_at_done", busy_o, 0);
            checkOutput("cs_n_at_done", cs_n_o, 1);
            if (e.chkTx) begin
              checkOutput("mosi_word", txCap, e.tx);
              checkOutput("sclk_rises", riseCnt, DATA_W);
            end
          end
        end
        lastDone = done_o;
      end
    end
  end

  initial begin
    int                d0;
    int                posSeen;
    int                n;
    logic [6:0]        bits;

    vecs[0] = '{tx: 8'hA5, pattern: 8'h3C, expRx: 8'h3C, expMosi: 8'hA5};
    vecs[1] = '{tx: 8'h5A, pattern: 8'hC3, expRx: 8'hC3, expMosi: 8'h5A};
    vecs[2] = '{tx: 8'h00, pattern: 8'hFF, expRx: 8'hFF, expMosi: 8'h00};
    vecs[3] = '{tx: 8'h81, pattern: 8'h7E, expRx: 8'h7E, expMosi: 8'h81};
    vecs[4] = '{tx: 8'hFF, pattern: 8'h00, expRx: 8'h00, expMosi: 8'hFF};

    rst_i = 1'b1;
    start_i = 1'b0;
    tx_data_i = '0;
    forceMode = 1'b0;
    fPos = 1'b0;
    fNeg = 1'b0;
    fMiso = 1'b0;
    slavePattern = '0;

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk_10MHz);
    checkOutput("rst_cs_n", cs_n_o, 1);
    checkOutput("rst_en_sclk", en_sclk_o, 0);
    rst_i = 1'b0;
    @(negedge clk_10MHz);
    checkOutput("idle_cs_n", cs_n_o, 1);
    checkOutput("idle_en_sclk", en_sclk_o, 0);
    checkOutput("idle_mosi", mosi_o, 0);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("idle_done", done_o, 0);
    checkOutput("idle_rx", rx_data_o, 0);

    // Table of ordinary transfers through the divider and slave models.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].tx, vecs[i].pattern, vecs[i].expRx, vecs[i].expMosi, 1'b1);
      checkOutput("busy_after_start", busy_o, 1);
      waitDone(300, "wait_table_done");
      repeat (3) @(negedge clk_10MHz);
    end

    // Back-to-back: start held high, second word loaded in the done cycle.
    sbq.push_back('{rx: 8'h5A, tx: 8'hFF, chkTx: 1'b1});
    sbq.push_back('{rx: 8'h96, tx: 8'h00, chkTx: 1'b1});
    slavePattern = 8'h5A;
    tx_data_i = 8'hFF;
    start_i = 1'b1;
    @(negedge clk_10MHz);
    waitDone(300, "wait_b2b_first");
    tx_data_i = 8'h00;
    slavePattern = 8'h96;
    @(negedge clk_10MHz);
    checkOutput("b2b_cs_gap", cs_n_o, 0);
    checkOutput("b2b_busy", busy_o, 1);
    start_i = 1'b0;
    waitDone(300, "wait_b2b_second");
    repeat (3) @(negedge clk_10MHz);

    // Start and data changes during a transfer must be ignored.
    applyStimulus(8'hC3, 8'h3C, 8'h3C, 8'hC3, 1'b1);
    d0 = doneCount;
    waitEn(20, "wait_ignore_en");
    start_i = 1'b1;
    tx_data_i = 8'h11;
    @(negedge clk_10MHz);
    start_i = 1'b0;
    waitDone(300, "wait_ignore_done");
    repeat (20) @(negedge clk_10MHz);
    checkOutput("ignore_single_done", doneCount - d0, 1);
    checkOutput("ignore_idle_cs", cs_n_o, 1);

    // Simultaneous strobes: the sample happens, the MOSI update does not.
    forceMode = 1'b1;
    applyStimulus(8'hA5, 8'h00, 8'hB3, 8'h00, 1'b0);
    waitEn(20, "wait_both_en");
    fPos = 1'b1;
    fNeg = 1'b1;
    fMiso = 1'b1;
    @(negedge clk_10MHz);
    fPos = 1'b0;
    fNeg = 1'b0;
    checkOutput("both_mosi_hold", mosi_o, 1);
    bits = 7'b0110011;
    for (int k = 0; k < 7; k++) begin
      fPos = 1'b1;
      fMiso = bits[6-k];
      @(negedge clk_10MHz);
      fPos = 1'b0;
      fNeg = 1'b1;
      @(negedge clk_10MHz);
      fNeg = 1'b0;
      if (k == 0) checkOutput("both_next_bit", mosi_o, 0);
      if (k == 5) checkOutput("both_not_early", en_sclk_o, 1);
    end
    checkOutput("both_frame_end", en_sclk_o, 0);
    waitDone(50, "wait_both_done");
    repeat (2) @(negedge clk_10MHz);
    forceMode = 1'b0;
    repeat (2) @(negedge clk_10MHz);

    // Asynchronous reset after the third rising strobe aborts the transfer.
    applyStimulus(8'hA5, 8'h3C, 8'h3C, 8'hA5, 1'b1);
    posSeen = 0;
    n = 0;
    while (posSeen < 3 && n < 200) begin
      @(negedge clk_10MHz);
      if (pos_edge_i) posSeen++;
      n++;
    end
    if (posSeen < 3) timeoutFail("wait_abort_pos");
    #10;
    rst_i = 1'b1;
    #1;
    checkOutput("abort_cs_n", cs_n_o, 1);
    checkOutput("abort_en_sclk", en_sclk_o, 0);
    checkOutput("abort_mosi", mosi_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_done", done_o, 0);
    checkOutput("abort_rx", rx_data_o, 0);
    sbq.delete();
    d0 = doneCount;
    repeat (2) @(negedge clk_10MHz);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_10MHz);
    checkOutput("abort_no_done", doneCount - d0, 0);
    checkOutput("abort_rx_held", rx_data_o, 0);
    applyStimulus(8'h3C, 8'hA5, 8'hA5, 8'h3C, 1'b1);
    waitDone(300, "wait_after_abort");
    repeat (3) @(negedge clk_10MHz);

    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
